// File: rtl/bitmask_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bitmask_decode_arbiter
// Purpose  : Round-robin arbiter that shares one immediate/bitmask decoder
//            (ARM DecodeBitMasks) between NUM_REQ requesters. The granted
//            operands are latched, decoded in one cycle, trimmed for 32-bit
//            use and checked for reserved encodings. The result is returned,
//            tagged with the requester index, on a valid/ready channel.
// Ports    : clk, nreset          - clock, async active-low reset
//            req_valid/req_ready  - per-requester handshake (ready one-hot)
//            req_immr/req_imms    - 6-bit fields, requester i at [6i+5:6i]
//            req_n/req_sf         - N bit, 1 = 64-bit operation
//            req_logical          - 1 = logical immediate, 0 = bitfield use
//            rsp_valid/rsp_ready  - response handshake
//            rsp_id               - index of the requester served
//            rsp_wmask/rsp_tmask  - decoded masks (zero when rsp_err)
//            rsp_err              - reserved/illegal encoding
// Revision : 1.0 - initial release
// ============================================================================
module bitmask_decode_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [6*NUM_REQ-1:0] req_immr,
  input  logic [6*NUM_REQ-1:0] req_imms,
  input  logic [NUM_REQ-1:0]   req_n,
  input  logic [NUM_REQ-1:0]   req_sf,
  input  logic [NUM_REQ-1:0]   req_logical,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_wmask,
  output logic [63:0]          rsp_tmask,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Latched operands of the granted request
  logic [5:0]      immr_q, imms_q;
  logic            n_q, sf_q, logical_q;
  logic [ID_W-1:0] id_q;

  // Result registers
  logic [63:0]     wmask_q, tmask_q;
  logic            err_q;

  // Arbitration
  logic [NUM_REQ-1:0][5:0] w_immr_arr, w_imms_arr;
  logic [ID_W-1:0]         w_scan_idx, w_grant_idx;
  logic                    w_grant_found;

  assign w_immr_arr = req_immr;
  assign w_imms_arr = req_imms;

  // Search upward from the pointer with explicit wrap, so a non power-of-two
  // NUM_REQ never produces an out-of-range index.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan_idx    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant_found && req_valid[w_scan_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx;
      end
      w_scan_idx = (w_scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_scan_idx + 1'b1;
    end
  end

  // Gated by nreset so req_ready is low while reset is held.
  always_comb begin
    req_ready = '0;
    if (nreset && state_q == S_IDLE && w_grant_found) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Shared decoder, driven by the latched operands
  logic [6:0]  w_len_bits;
  logic [2:0]  w_len;
  logic [5:0]  w_levels, w_s, w_r, w_d;
  logic [63:0] w_wrep, w_trep, w_wmask, w_tmask;
  logic        w_err;

  always_comb begin
    w_len_bits = {n_q, ~imms_q};
    w_len      = 3'd0;
    for (int j = 0; j < 7; j++) begin
      if (w_len_bits[j]) w_len = 3'(j);
    end
  end

  assign w_levels = 6'((7'd1 << w_len) - 7'd1);
  assign w_s      = imms_q & w_levels;
  assign w_r      = immr_q & w_levels;
  assign w_d      = (w_s - w_r) & w_levels;

  // Element bit j is set when j <= S (resp. j <= d). Masking the bit index
  // with levels replicates the element; adding R before masking rotates the
  // element right by R.
  always_comb begin
    w_wrep = '0;
    w_trep = '0;
    for (int i = 0; i < 64; i++) begin
      w_wrep[i] = ((6'(i) + w_r) & w_levels) <= w_s;
      w_trep[i] = (6'(i) & w_levels) <= w_d;
    end
  end

  assign w_err   = (w_len == 3'd0) | (~sf_q & n_q) | (logical_q & (w_s == w_levels));
  assign w_wmask = w_err ? 64'd0 : (sf_q ? w_wrep : {32'd0, w_wrep[31:0]});
  assign w_tmask = w_err ? 64'd0 : (sf_q ? w_trep : {32'd0, w_trep[31:0]});

  // FSM next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE:   if (w_grant_found) state_d = S_DECODE;
      S_DECODE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      immr_q    <= '0;
      imms_q    <= '0;
      n_q       <= 1'b0;
      sf_q      <= 1'b0;
      logical_q <= 1'b0;
      id_q      <= '0;
    end else if (state_q == S_IDLE && w_grant_found) begin
      immr_q    <= w_immr_arr[w_grant_idx];
      imms_q    <= w_imms_arr[w_grant_idx];
      n_q       <= req_n[w_grant_idx];
      sf_q      <= req_sf[w_grant_idx];
      logical_q <= req_logical[w_grant_idx];
      id_q      <= w_grant_idx;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wmask_q <= '0;
      tmask_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_DECODE) begin
      wmask_q <= w_wmask;
      tmask_q <= w_tmask;
      err_q   <= w_err;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_wmask = wmask_q;
  assign rsp_tmask = tmask_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire
